pacman_soc_nios2_debug_mem_access: RTL and testbench
====================================================

// Module: pacman_soc_nios2_debug_mem_access
// PURPOSE
//  Sysclk-domain consumer of the debug slave's jdo / take_action_ocimem_* strobes.
//  Turns JTAG monitor commands into single-word Avalon-MM master reads and writes with an auto-incrementing address.
//  Returns MonDReg, monitor_ready and monitor_error to the debug slave TCK capture path.
//  Sits between the CPU debug slave wrapper and the SoC interconnect.
// PARAMETERS
//  ADDR_W        11    word-address width; m_address is ADDR_W+2 bits (byte address, low 2 bits 0)
//  TIMEOUT_CYC   1023  max cycles a transfer may stall on m_waitrequest before abort
// PORTS
//  clk                     in   1       system clock
//  reset_n                 in   1       asynchronous active-low reset
//  jdo                     in   38      command payload from debug slave
//  take_action_ocimem_a    in   1       1-cycle strobe: load address (+optional read)
//  take_no_action_ocimem_a in   1       1-cycle strobe: optional read at current address
//  take_action_ocimem_b    in   1       1-cycle strobe: write jdo[34:3] at current address
//  MonDReg                 out  32      last read data / echoed write data
//  monitor_ready           out  1       1 = idle, result valid
//  monitor_error           out  1       timeout or dropped command since last accepted command
//  m_address               out  ADDR_W+2  byte address = {addr, 2'b00}
//  m_read                  out  1       Avalon read request
//  m_write                 out  1       Avalon write request
//  m_writedata             out  32      write data
//  m_byteenable            out  4       constant 4'hF
//  m_readdata              in   32      read data, valid when m_read && !m_waitrequest
//  m_waitrequest           in   1       slave stall
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - State IDLE; addr=0; MonDReg=0; monitor_ready=1; monitor_error=0.
//   - m_read=m_write=0; m_writedata=0; timeout count=0.
//  FSM states: IDLE, READ, WRITE. Strobe priority: ocimem_a > no_action_a > ocimem_b.
//  IDLE
//   - ocimem_a: addr<=jdo[ADDR_W+1:2]; if jdo[35], go READ.
//   - no_action_a with jdo[35]: go READ.
//   - ocimem_b: m_writedata<=jdo[34:3]; MonDReg<=jdo[34:3]; go WRITE.
//   - Any accepted strobe clears monitor_error. monitor_ready drops in the cycle after the strobe whenever a transfer starts.
//  READ
//   - m_read=1 and m_address held until !m_waitrequest.
//   - That cycle: MonDReg<=m_readdata; addr<=addr+1; return to IDLE; monitor_ready=1 next cycle.
//   - Min latency strobe->ready = 2 cycles.
//  WRITE
//   - m_write=1 with data held until !m_waitrequest; then addr<=addr+1; return to IDLE.
//  Address arithmetic
//   - addr is ADDR_W bits, unsigned, and wraps all-ones->0 silently.
//   - ocimem_a without the read bit only loads addr; it does not increment.
//  Timeout
//   - Counter runs in READ/WRITE while m_waitrequest=1.
//   - On reaching TIMEOUT_CYC: deassert request; monitor_error<=1; MonDReg unchanged; addr not incremented; return to IDLE.
//  Busy collision
//   - Any strobe in READ/WRITE is dropped and sets monitor_error=1. The in-flight transfer continues.
//  Reset mid-transfer: request lines drop immediately (async); no completion is reported.
// STRUCTURE
//  - Shared include pacman_soc_debug_defs.vh: FSM state encodings, JDO_RD_BIT=35, JDO_WDATA_LSB=3, JDO_ADDR_LSB=2.
//  - One sub-module: pacman_soc_debug_mem_timeout (loadable stall counter, clear/expire outputs).
//  - Rest is one FSM plus an address/data register file.
// TESTING
//  1. Reset, then ocimem_a with jdo[ADDR_W+1:2]=5, jdo[35]=1; slave returns 32'hDEADBEEF with 0 wait
//     -> m_address=20, MonDReg=DEADBEEF, addr=6, ready high 2 cycles after strobe.
//  2. ocimem_b with jdo[34:3]=32'h12345678, 3 wait cycles
//     -> m_write held 4 cycles, m_writedata stable, addr increments once, error=0.
//  3. addr=all-ones, no_action_a read -> completes, addr wraps to 0.
//  4. m_waitrequest stuck 1 on a read -> m_read drops after TIMEOUT_CYC; error=1; MonDReg and addr unchanged; next strobe clears error.
//  5. ocimem_b strobe while READ is stalled -> strobe ignored, error=1, read completes normally.
//  6. ocimem_a and ocimem_b in the same cycle -> only address load/read occurs.
//     Also: reset asserted mid-WRITE -> m_write=0 at once, reset values restored.

Source files
------------

// File: rtl/pacman_soc_nios2_debug_mem_access_pkg.sv
// Shared definitions for the Nios II debug memory-access path:
// FSM state encoding and the jdo command field positions.
package pacman_soc_nios2_debug_mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } mem_state_e;

  localparam int JDO_W         = 38;
  localparam int JDO_RD_BIT    = 35;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_ADDR_LSB  = 2;
  localparam int DATA_W        = 32;

endpackage

// File: rtl/pacman_soc_debug_mem_timeout.sv
// Stall watchdog: down-counter loaded at transfer start, decremented on each
// stalled cycle; expires on the stalled cycle that finds it at zero.
module pacman_soc_debug_mem_timeout #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic stall,
  output logic expire,
  output logic clear
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (stall && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign clear  = (cnt_q == '0);
  assign expire = stall && clear;

endmodule

// File: rtl/pacman_soc_nios2_debug_mem_access.sv
// Turns debug-slave ocimem strobes into single-word Avalon-MM reads/writes
// with an auto-incrementing word address and a stall timeout.
//
//  state    | meaning
//  ST_IDLE  | ready for a command, MonDReg valid
//  ST_READ  | m_read asserted until !m_waitrequest or timeout
//  ST_WRITE | m_write asserted until !m_waitrequest or timeout
module pacman_soc_nios2_debug_mem_access
  import pacman_soc_nios2_debug_mem_access_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [JDO_W-1:0]    jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_no_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error,
  output logic [ADDR_W+1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [3:0]          m_byteenable,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_waitrequest
);

  mem_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   mon_q, mon_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;

  logic                busy;
  logic                any_strobe;
  logic                tmo_load;
  logic                tmo_expire;
  logic                tmo_clear;

  assign busy       = (state_q != ST_IDLE);
  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  pacman_soc_debug_mem_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmo_load),
    .stall   (busy && m_waitrequest),
    .expire  (tmo_expire),
    .clear   (tmo_clear)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    mon_d    = mon_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    tmo_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (take_action_ocimem_a) begin
          addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
          err_d  = 1'b0;
          if (jdo[JDO_RD_BIT]) begin
            state_d  = ST_READ;
            tmo_load = 1'b1;
          end
        end else if (take_no_action_ocimem_a) begin
          err_d = 1'b0;
          if (jdo[JDO_RD_BIT]) begin
            state_d  = ST_READ;
            tmo_load = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          wdata_d  = jdo[JDO_WDATA_LSB +: DATA_W];
          mon_d    = jdo[JDO_WDATA_LSB +: DATA_W];
          err_d    = 1'b0;
          state_d  = ST_WRITE;
          tmo_load = 1'b1;
        end
      end
      ST_READ, ST_WRITE: begin
        if (!m_waitrequest) begin
          if (state_q == ST_READ) begin
            mon_d = m_readdata;
          end
          addr_d  = addr_q + 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
        // Strobes arriving mid-transfer are dropped; the transfer carries on.
        if (any_strobe) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mon_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mon_q   <= mon_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Request lines decode straight from state so reset drops them at once.
  assign m_read        = (state_q == ST_READ);
  assign m_write       = (state_q == ST_WRITE);
  assign m_address     = {addr_q, 2'b00};
  assign m_writedata   = wdata_q;
  assign m_byteenable  = 4'hF;
  assign MonDReg       = mon_q;
  assign monitor_ready = !busy;
  assign monitor_error = err_q;

endmodule

// File: tb/tb_pacman_soc_nios2_debug_mem_access.sv
// Scoreboard bench: commands push expected requests/completions, a negedge
// monitor pops and compares as the DUT presents them.
module tb_pacman_soc_nios2_debug_mem_access;

  localparam int ADDR_W = 11;
  localparam int TMO    = 1023;
  localparam int KA = 0, KN = 1, KB = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [37:0]       jdo = '0;
  logic              take_action_ocimem_a = 1'b0;
  logic              take_no_action_ocimem_a = 1'b0;
  logic              take_action_ocimem_b = 1'b0;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic [ADDR_W+1:0] m_address;
  logic              m_read;
  logic              m_write;
  logic [31:0]       m_writedata;
  logic [3:0]        m_byteenable;
  logic [31:0]       m_readdata = '0;
  logic              m_waitrequest = 1'b0;

  always #5 clk = ~clk;

  pacman_soc_nios2_debug_mem_access #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
  );

  typedef struct {
    bit                is_wr;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       wdata;
    int                len;
  } req_t;

  typedef struct {
    logic [31:0]       mon;
    logic [ADDR_W+1:0] addr;
    logic              err;
  } cmp_t;

  req_t req_q[$];
  cmp_t cmp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: word address, last monitor data, sticky error.
  int          mdl_addr = 0;
  logic [31:0] mdl_mon  = '0;
  logic        mdl_err  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W+1:0] byte_addr(input int word);
    return (ADDR_W+2)'(word * 4);
  endfunction

  // Monitor
  bit   req_prev = 1'b0;
  bit   rdy_prev = 1'b1;
  bit   held_ok  = 1'b1;
  int   req_len  = 0;
  req_t cur;

  always @(negedge clk) begin
    if (!reset_n) begin
      req_prev = 1'b0;
      rdy_prev = 1'b1;
    end else begin
      if ((m_read || m_write) && !req_prev) begin
        if (req_q.size() == 0) begin
          check("unexpected_request", 1, 0);
          cur = '{is_wr: m_write, addr: m_address, wdata: m_writedata, len: -1};
        end else begin
          cur = req_q.pop_front();
          check("req_kind", {m_read, m_write}, {!cur.is_wr, cur.is_wr});
          check("req_addr", m_address, cur.addr);
          if (cur.is_wr) check("req_wdata", m_writedata, cur.wdata);
          check("req_byteen", m_byteenable, 4'hF);
          check("req_ready_low", monitor_ready, 0);
        end
        req_len = 1;
        held_ok = 1'b1;
      end else if (m_read || m_write) begin
        req_len++;
        if (m_address !== cur.addr || (cur.is_wr && m_writedata !== cur.wdata) ||
            m_write !== cur.is_wr)
          held_ok = 1'b0;
      end
      if (!(m_read || m_write) && req_prev) begin
        check("req_len", req_len, cur.len);
        check("req_held", held_ok, 1);
      end
      if (monitor_ready && !rdy_prev) begin
        if (cmp_q.size() == 0) begin
          check("unexpected_completion", 1, 0);
        end else begin
          cmp_t c;
          c = cmp_q.pop_front();
          check("cmp_mondreg", MonDReg, c.mon);
          check("cmp_addr", m_address, c.addr);
          check("cmp_error", monitor_error, c.err);
        end
      end
      req_prev = m_read || m_write;
      rdy_prev = monitor_ready;
    end
  end

  // One command; DUT assumed idle. The slave stalls 'waits' cycles (or forever if stuck).
  task automatic run_cmd(input int kind, input logic rd, input int a, input logic [31:0] wd,
                         input int waits, input logic [31:0] rdata, input bit stuck,
                         input bit collide, input bit both);
    logic [37:0] j;
    bit starts;
    bit wr;
    int cyc;
    j = {$urandom, $urandom};
    j[35] = rd;
    if (kind == KB) j[34:3] = wd;
    if (kind == KA) j[ADDR_W+1:2] = ADDR_W'(a);
    wr     = (kind == KB);
    starts = wr || rd;

    @(posedge clk); #1;
    jdo = j;
    take_action_ocimem_a    = (kind == KA);
    take_no_action_ocimem_a = (kind == KN);
    take_action_ocimem_b    = (kind == KB) || both;

    if (kind == KA) mdl_addr = a;
    mdl_err = 1'b0;
    if (starts) begin
      req_q.push_back('{is_wr: wr, addr: byte_addr(mdl_addr), wdata: wd,
                        len: stuck ? TMO : waits + 1});
      if (wr) mdl_mon = wd;
      if (stuck) begin
        mdl_err = 1'b1;
      end else begin
        if (!wr) mdl_mon = rdata;
        mdl_addr = (mdl_addr + 1) % (1 << ADDR_W);
        mdl_err  = collide;
      end
      cmp_q.push_back('{mon: mdl_mon, addr: byte_addr(mdl_addr), err: mdl_err});
    end

    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    if (!starts) begin
      check("noxfer_addr", m_address, byte_addr(mdl_addr));
      check("noxfer_error", monitor_error, mdl_err);
      check("noxfer_idle", {monitor_ready, m_read, m_write}, 3'b100);
      return;
    end
    m_readdata    = rdata;
    m_waitrequest = stuck || (waits > 0);
    cyc = 0;
    while (!monitor_ready && cyc < TMO + 10) begin
      @(posedge clk); #1;
      cyc++;
      take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
      if (collide && cyc == 1) begin
        jdo = {$urandom, $urandom};
        case ($urandom_range(2))
          0: take_action_ocimem_a = 1'b1;
          1: take_no_action_ocimem_a = 1'b1;
          default: take_action_ocimem_b = 1'b1;
        endcase
      end
      if (!stuck && cyc >= waits) m_waitrequest = 1'b0;
    end
    if (!monitor_ready) check("ready_timeout", 0, 1);
    m_waitrequest = 1'b0;
  endtask

  initial begin
    int   ra, rk, rw;
    logic rrd;
    bit   rc;

    #2;
    check("rst_mondreg", MonDReg, 0);
    check("rst_flags", {monitor_ready, monitor_error, m_read, m_write}, 4'b1000);
    check("rst_addr", m_address, 0);
    check("rst_wdata", m_writedata, 0);
    check("rst_byteen", m_byteenable, 4'hF);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    run_cmd(KA, 1'b1, 5, 32'h0, 0, 32'hDEADBEEF, 0, 0, 0);
    run_cmd(KB, 1'b0, 0, 32'h12345678, 3, 32'h0, 0, 0, 0);
    run_cmd(KA, 1'b0, (1 << ADDR_W) - 1, 32'h0, 0, 32'h0, 0, 0, 0);
    run_cmd(KN, 1'b1, 0, 32'h0, 1, 32'hCAFEF00D, 0, 0, 0);
    run_cmd(KN, 1'b1, 0, 32'h0, 0, 32'h11112222, 1, 0, 0);
    run_cmd(KA, 1'b0, 3, 32'h0, 0, 32'h0, 0, 0, 0);
    run_cmd(KN, 1'b1, 0, 32'h0, 3, 32'hA5A55A5A, 0, 1, 0);
    run_cmd(KA, 1'b1, 9, 32'h0, 0, 32'h76543210, 0, 0, 1);
    run_cmd(KB, 1'b1, 0, 32'hFEEDFACE, 0, 32'h0, 1, 0, 0);
    run_cmd(KN, 1'b0, 0, 32'h0, 0, 32'h0, 0, 0, 0);

    // Reset asserted while a write is stalled.
    @(posedge clk); #1;
    jdo = '0; jdo[34:3] = 32'h0BADC0DE; take_action_ocimem_b = 1'b1;
    req_q.push_back('{is_wr: 1'b1, addr: byte_addr(mdl_addr), wdata: 32'h0BADC0DE, len: 0});
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0; m_waitrequest = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_req", {m_read, m_write}, 2'b00);
    check("midrst_flags", {monitor_ready, monitor_error}, 2'b10);
    check("midrst_regs", {MonDReg, m_writedata}, 64'h0);
    check("midrst_addr", m_address, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; m_waitrequest = 1'b0;
    mdl_addr = 0; mdl_mon = '0; mdl_err = 1'b0;

    for (int i = 0; i < 60; i++) begin
      rk  = $urandom_range(2);
      rrd = 1'($urandom_range(1));
      ra  = $urandom_range((1 << ADDR_W) - 1);
      rw  = $urandom_range(4);
      rc  = (rw >= 2) && (rk == KB || rrd) && ($urandom_range(3) == 0);
      run_cmd(rk, rrd, ra, $urandom, rw, $urandom, 0, rc, 0);
    end

    repeat (5) @(posedge clk);
    check("req_q_drained", req_q.size(), 0);
    check("cmp_q_drained", cmp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
